// File: rtl/mau_pkg.sv
// Shared encodings and op-class helpers for the load/store sequencer.
package mau_pkg;

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LHU = 3'd2;
   localparam logic [2:0] OP_LB  = 3'd3;
   localparam logic [2:0] OP_LBU = 3'd4;
   localparam logic [2:0] OP_SW  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SB  = 3'd7;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   // Big-endian: lane 0 is the most significant byte of the word.
   localparam logic [1:0] LANE_B0 = 2'd0;
   localparam logic [1:0] LANE_B1 = 2'd1;
   localparam logic [1:0] LANE_B2 = 2'd2;
   localparam logic [1:0] LANE_B3 = 2'd3;

   function automatic logic is_store(input logic [2:0] op);
      return op inside {OP_SW, OP_SH, OP_SB};
   endfunction

   function automatic logic is_half(input logic [2:0] op);
      return op inside {OP_LH, OP_LHU, OP_SH};
   endfunction

   function automatic logic is_byte(input logic [2:0] op);
      return op inside {OP_LB, OP_LBU, OP_SB};
   endfunction

   function automatic logic is_word(input logic [2:0] op);
      return op inside {OP_LW, OP_SW};
   endfunction

   function automatic logic misaligned(input logic [2:0] op,
                                       input logic [1:0] off);
      return (is_half(op) & off[0]) | (is_word(op) & (off != 2'd0));
   endfunction

endpackage

// File: rtl/mau_lane_merge.sv
// Big-endian lane extract/extend for loads and lane replace for stores.
module mau_lane_merge
   import mau_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  op,
   input  logic [31:0] store_data,
   output logic [31:0] load_value,
   output logic [31:0] merged
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = word[7:0];
      unique case (offset)
         LANE_B0: lane_b = word[31:24];
         LANE_B1: lane_b = word[23:16];
         LANE_B2: lane_b = word[15:8];
         LANE_B3: lane_b = word[7:0];
         default: lane_b = word[7:0];
      endcase
      lane_h = offset[1] ? word[15:0] : word[31:16];

      load_value = word;
      unique case (op)
         OP_LH:   load_value = {{16{lane_h[15]}}, lane_h};
         OP_LHU:  load_value = {16'h0, lane_h};
         OP_LB:   load_value = {{24{lane_b[7]}}, lane_b};
         OP_LBU:  load_value = {24'h0, lane_b};
         default: load_value = word;
      endcase

      merged = word;
      if (op == OP_SW) begin
         merged = store_data;
      end else if (is_half(op)) begin
         merged = offset[1] ? {word[31:16], store_data[15:0]}
                            : {store_data[15:0], word[15:0]};
      end else if (is_byte(op)) begin
         unique case (offset)
            LANE_B0: merged = {store_data[7:0], word[23:0]};
            LANE_B1: merged = {word[31:24], store_data[7:0], word[15:0]};
            LANE_B2: merged = {word[31:16], store_data[7:0], word[7:0]};
            LANE_B3: merged = {word[31:8], store_data[7:0]};
            default: merged = word;
         endcase
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer with sub-word read-modify-write stores.
// Optional MEM_ACCESS_UNIT_RANGE_CHECK_EN rejects accesses beyond MEM_BYTES.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int MEM_BYTES = 32
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Start,
   input  logic [2:0]  Op,
   input  logic [31:0] Addr,
   input  logic [31:0] StoreData,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] LoadData,
   output logic        AlignErr,
   output logic        MemRD,
   output logic        MemWR,
   output logic [31:0] MemAddr,
   output logic [31:0] MemDataOut,
   input  logic [31:0] MemDataIn
);

   logic [1:0]  state;
   logic [2:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] sdata_q;
   logic [31:0] merge_q;
   logic        err_q;
   logic        bad;
   logic [31:0] lane_word;
   logic [31:0] load_value;
   logic [31:0] merged;

`ifdef MEM_ACCESS_UNIT_RANGE_CHECK_EN
   // Last byte of the addressed word must lie inside the memory.
   logic out_of_range;
   assign out_of_range =
      ({1'b0, Addr[31:2], 2'b11} >= 33'(MEM_BYTES));
   assign bad = misaligned(Op, Addr[1:0]) | out_of_range;
`else
   assign bad = misaligned(Op, Addr[1:0]);
`endif

   assign lane_word = (state == S_READ) ? MemDataIn : merge_q;

   mau_lane_merge u_lane (
      .word       (lane_word),
      .offset     (addr_q[1:0]),
      .op         (op_q),
      .store_data (sdata_q),
      .load_value (load_value),
      .merged     (merged)
   );

   assign Busy       = (state != S_IDLE);
   assign Done       = (state == S_FIN);
   assign AlignErr   = Done & err_q;
   assign MemRD      = (state == S_READ);
   assign MemWR      = (state == S_WRITE);
   assign MemAddr    = {addr_q[31:2], 2'b00};
   assign MemDataOut = merged;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state    <= S_IDLE;
         op_q     <= '0;
         addr_q   <= '0;
         sdata_q  <= '0;
         merge_q  <= '0;
         err_q    <= 1'b0;
         LoadData <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (Start) begin
                  op_q    <= Op;
                  addr_q  <= Addr;
                  sdata_q <= StoreData;
                  err_q   <= bad;
                  unique case (1'b1)
                     bad:          state <= S_FIN;
                     (Op == OP_SW): state <= S_WRITE;
                     default:      state <= S_READ;
                  endcase
               end
            end
            S_READ: begin
               if (is_store(op_q)) begin
                  merge_q <= MemDataIn;
                  state   <= S_WRITE;
               end else begin
                  LoadData <= load_value;
                  state    <= S_FIN;
               end
            end
            S_WRITE: state <= S_FIN;
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer between the multi-cycle control unit and the data memory.
- Data memory is big-endian and byte-addressed, with 32-bit word reads and writes:
  - read is combinational while RD=1;
  - write happens on posedge CLK while WR=1.
- Adds byte and halfword loads and stores, with sign or zero extension, and alignment checking.
- Sub-word stores are done as read-modify-write over two memory cycles.

Parameters:
- MEM_BYTES, 32, data memory size in bytes; used only by the optional range check.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request strobe; sampled only in IDLE.
- Op  in  3  access type: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
- Addr  in  32  byte address.
- StoreData  in  32  store source; low byte or half is used for SB/SH.
- Busy  out  1  high in every state other than IDLE.
- Done  out  1  one-cycle completion pulse.
- LoadData  out  32  extended load result; held until the next load completes.
- AlignErr  out  1  valid with Done; misaligned access, no memory side effect.
- MemRD  out  1  to memory RD.
- MemWR  out  1  to memory WR.
- MemAddr  out  32  to memory DAddr; always the word address {Addr_q[31:2],2'b00}.
- MemDataOut  out  32  to memory DataIn.
- MemDataIn  in  32  from memory DataOut.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; Busy, Done, AlignErr, MemRD, MemWR all 0; LoadData=0; internal regs cleared.
- Capture: in IDLE with Start=1, register Op, Addr and StoreData into Op_q, Addr_q, SData_q.
  - Start while Busy is ignored.
  - Inputs may change after the capture edge.
- States: IDLE, READ, WRITE, FIN.
- Alignment rules:
  - LW/SW need Addr[1:0]=0.
  - LH/LHU/SH need Addr[0]=0.
  - Bytes are always aligned.
- Transitions:
  - IDLE, Start and misaligned -> FIN with AlignErr set. No memory strobe ever asserted.
  - IDLE, Start, aligned store SW -> WRITE.
  - IDLE, Start, aligned other ops -> READ.
  - READ, load -> FIN. MemRD=1; LoadData updated at the end of READ from MemDataIn.
  - READ, SH/SB -> WRITE. MemRD=1; the read word is latched into a merge register.
  - WRITE -> FIN. MemWR=1; memory commits at the closing edge of WRITE.
  - FIN -> IDLE. Done=1 for exactly one cycle; AlignErr is meaningful only here.
- Latency (Start edge to Done high):
  - LW/LH/LB/SW: 2 cycles.
  - SH/SB: 3 cycles.
  - Misaligned: 1 cycle.
  - Back-to-back: the next Start is accepted on the cycle Done is high? No — it is accepted in the IDLE cycle after FIN, so minimum issue interval is latency+1.
- Memory strobes:
  - MemRD and MemWR are decoded from state only (Moore), never both high.
  - MemRD=0 outside READ; MemWR=0 outside WRITE.
- Byte lanes (big-endian):
  - Offset 0 -> bits [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - Halfword at offset 0 -> [31:16]; at offset 2 -> [15:0].
- Loads:
  - LB/LH sign-extend from the lane MSB.
  - LBU/LHU zero-extend.
  - LW is passed through unchanged.
- Stores:
  - SW: MemDataOut=SData_q.
  - SH/SB: MemDataOut = merge word with only the addressed lane replaced by SData_q[15:0] or SData_q[7:0].
- Reset mid-operation: the state returns to IDLE at the reset edge.
  - If the reset edge closes a WRITE cycle, memory still commits that write, since WR was high at that edge. This is accepted behaviour.
  - No write is issued after reset.
- LoadData is unchanged by stores and by errored accesses.

Optional Feature:
- Macro: MEM_ACCESS_UNIT_RANGE_CHECK_EN.
- Defined: in IDLE, an access with Addr[31:2]*4+3 >= MEM_BYTES is treated exactly like a misaligned access: FIN with AlignErr=1, no strobes.
- Undefined: no range check; the address passes through to memory unmodified.

Decomposition:
- Shared package mau_pkg:
  - Op encodings (OP_LW..OP_SB).
  - State encoding (S_IDLE, S_READ, S_WRITE, S_FIN).
  - Lane-offset constants.
  - is_store / is_half / is_byte helper functions.
- One natural sub-module: mau_lane_merge, purely combinational.
  - Inputs: word, offset, op, store data.
  - Outputs: extracted and extended load value, merged store word.
  - Instantiated once; all sequencing stays in mem_access_unit.

Test Plan:
- Memory word 0x80F17F02 at address 8:
  - LB Addr=9 -> Done at cycle 2, LoadData=0xFFFFFFF1.
  - LBU Addr=9 -> 0x000000F1.
  - LB Addr=10 -> 0x0000007F.
- Same word:
  - LH Addr=8 -> 0xFFFF80F1.
  - LHU Addr=10 -> 0x00007F02.
  - LW Addr=8 -> 0x80F17F02.
- SB Addr=11, StoreData=0x123456AA over 0x80F17F02:
  - MemRD in cycle 1, MemWR in cycle 2, Done in cycle 3.
  - Memory word becomes 0x80F17FAA.
- SH Addr=8, StoreData=0xBEEF -> word becomes 0xBEEF7F02. A following SW Addr=8 of 0x01020304 gives LW 0x01020304.
- Misaligned accesses:
  - LW Addr=6 -> Done next cycle, AlignErr=1, MemRD/MemWR never high, LoadData unchanged.
  - SH Addr=5 -> same result.
- Start pulsed during Busy of an SB is ignored, with exactly one Done.
- Reset asserted during READ of an SB: next cycle IDLE, Busy=0, MemWR never asserted, memory unchanged.
